// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle MIPS core.
// Sequences the shared ALU/memory/regfile datapath one micro-step per cycle and
// stalls on a variable-latency memory through the MemReady handshake.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   Op                opcode from the instruction register
//   MemReady          memory completes the current access this cycle
//   IRWrite..MemRead  write/load strobes (forced low while in reset)
//   IorD..ALUOp       datapath mux selects and ALU decoder control
//   Illegal, MemErr   one-cycle pulses: bad opcode, memory wait timeout
//   State             current state encoding (debug)
// Outputs are decoded from the current state (and MemReady/Op where needed), so
// they change in the same cycle the state is entered.
module multicycle_main_fsm #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] ALUOp,
  output logic       Illegal,
  output logic       MemErr,
  output logic [3:0] State
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11,
    ANDIEX  = 4'd12
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          is_wait;

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state, wait counter and output decode
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUOp    = 2'b00;
    Illegal  = 1'b0;
    MemErr   = 1'b0;

    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_ANDI:      state_d = ANDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d = FETCH;
            Illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) state_d = MEMWB;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = FETCH;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = IMMWB;
      end
      IMMWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = FETCH;
      end
      ANDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        state_d = IMMWB;
      end
      default: state_d = FETCH;
    endcase

    // Memory wait timeout: MemReady on the last allowed cycle still completes normally
    is_wait = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    if (is_wait && !MemReady) begin
      if ((TIMEOUT != 0) && (wait_q == CW'(TIMEOUT - 1))) begin
        MemErr  = 1'b1;
        state_d = FETCH;
      end else begin
        wait_d = wait_q + CW'(1);
      end
    end
    // A timeout in FETCH stays in FETCH, so it must restart the count explicitly
    if ((state_d != state_q) || MemErr) wait_d = '0;

    // Strobes are held off while reset is asserted; mux selects keep FETCH values
    if (!rst_n) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      Illegal  = 1'b0;
      MemErr   = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed testbench for multicycle_main_fsm (TIMEOUT=16).
// Each task starts and ends in FETCH, away from the clock edge.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] Op = 6'd0;
  logic       MemReady = 1'b0;
  logic       IRWrite, PCWrite, Branch, RegWrite, MemWrite, MemRead, IorD, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic       RegDst, MemtoReg, Illegal, MemErr;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_main_fsm #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUOp(ALUOp), .Illegal(Illegal), .MemErr(MemErr), .State(State)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    MemReady = 1'b1;
    #1;
    n_checks++;
    if (State !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", State);
    end
    n_checks++;
    if ({IRWrite, PCWrite, Branch, RegWrite, MemWrite, MemRead, Illegal, MemErr} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 00000000",
               {IRWrite, PCWrite, Branch, RegWrite, MemWrite, MemRead, Illegal, MemErr});
    end
    n_checks++;
    if ({IorD, ALUSrcA, ALUSrcB, ALUOp, PCSrc} !== 8'b0_0_01_00_00) begin
      n_fail++;
      $display("FAIL reset_muxes: got %b want 00010000", {IorD, ALUSrcA, ALUSrcB, ALUOp, PCSrc});
    end
    repeat (2) @(posedge clk);
    MemReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({State, MemRead, IRWrite} !== {4'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: got state=%0d MemRead=%b IRWrite=%b want 0 1 0",
               State, MemRead, IRWrite);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [6];
    exp_s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    Op = 6'b100011;
    MemReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (State !== exp_s[i]) begin
        n_fail++; $display("FAIL lw_state cyc%0d: got %0d want %0d", i, State, exp_s[i]);
      end
      n_checks++;
      if ({RegWrite, MemtoReg} !== {2{exp_s[i] == 4'd4}}) begin
        n_fail++;
        $display("FAIL lw_wb cyc%0d: got RegWrite=%b MemtoReg=%b want %b", i, RegWrite, MemtoReg,
                 exp_s[i] == 4'd4);
      end
      if (exp_s[i] == 4'd2) begin
        n_checks++;
        if ({ALUSrcA, ALUSrcB, ALUOp} !== 5'b1_10_00) begin
          n_fail++; $display("FAIL lw_memadr: got %b want 11000", {ALUSrcA, ALUSrcB, ALUOp});
        end
      end
      if (exp_s[i] == 4'd3) begin
        n_checks++;
        if ({IorD, MemRead} !== 2'b11) begin
          n_fail++; $display("FAIL lw_memrd: got IorD=%b MemRead=%b want 1 1", IorD, MemRead);
        end
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_s [5];
    exp_s = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    Op = 6'b000000;
    MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (State !== exp_s[i]) begin
        n_fail++; $display("FAIL r_state cyc%0d: got %0d want %0d", i, State, exp_s[i]);
      end
      if (i == 0) begin
        n_checks++;
        if ({IRWrite, PCWrite, ALUSrcB, PCSrc} !== 6'b1_1_01_00) begin
          n_fail++;
          $display("FAIL r_fetch: got %b want 110100", {IRWrite, PCWrite, ALUSrcB, PCSrc});
        end
      end
      if (i == 1) begin
        n_checks++;
        if ({ALUSrcA, ALUSrcB, ALUOp} !== 5'b0_11_00) begin
          n_fail++; $display("FAIL r_decode: got %b want 01100", {ALUSrcA, ALUSrcB, ALUOp});
        end
      end
      if (i == 2) begin
        n_checks++;
        if ({ALUSrcA, ALUSrcB, ALUOp, RegWrite} !== 6'b1_00_10_0) begin
          n_fail++;
          $display("FAIL r_execute: got %b want 100100", {ALUSrcA, ALUSrcB, ALUOp, RegWrite});
        end
      end
      if (i == 3) begin
        n_checks++;
        if ({RegDst, RegWrite, MemtoReg} !== 3'b110) begin
          n_fail++; $display("FAIL r_aluwb: got %b want 110", {RegDst, RegWrite, MemtoReg});
        end
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_branch_jump();
    Op = 6'b000100;
    MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (State !== ((i == 2) ? 4'd8 : (i == 1) ? 4'd1 : 4'd0)) begin
        n_fail++; $display("FAIL beq_state cyc%0d: got %0d", i, State);
      end
      if (i == 2) begin
        n_checks++;
        if ({Branch, PCSrc, ALUOp, ALUSrcA, ALUSrcB, PCWrite} !== 9'b1_01_01_1_00_0) begin
          n_fail++;
          $display("FAIL beq_ctrl: got %b want 101011000",
                   {Branch, PCSrc, ALUOp, ALUSrcA, ALUSrcB, PCWrite});
        end
      end
      if (i < 3) tick();
    end
    Op = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (State !== ((i == 2) ? 4'd11 : (i == 1) ? 4'd1 : 4'd0)) begin
        n_fail++; $display("FAIL j_state cyc%0d: got %0d", i, State);
      end
      if (i == 2) begin
        n_checks++;
        if ({PCWrite, PCSrc, Branch, RegWrite} !== 5'b1_10_0_0) begin
          n_fail++;
          $display("FAIL j_ctrl: got %b want 11000", {PCWrite, PCSrc, Branch, RegWrite});
        end
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_imm();
    // addi then andi: execute state, then IMMWB, then FETCH
    for (int k = 0; k < 2; k++) begin
      Op = (k == 0) ? 6'b001000 : 6'b001100;
      MemReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
        #1;
        if (i == 2) begin
          n_checks++;
          if ({State, ALUSrcA, ALUSrcB, ALUOp} !== {((k == 0) ? 4'd9 : 4'd12), 1'b1, 2'b10,
                                                   ((k == 0) ? 2'b00 : 2'b11)}) begin
            n_fail++;
            $display("FAIL imm_ex op%0d: got state=%0d ALUSrcB=%b ALUOp=%b", k, State, ALUSrcB, ALUOp);
          end
        end
        if (i == 3) begin
          n_checks++;
          if ({State, RegDst, MemtoReg, RegWrite} !== {4'd10, 3'b001}) begin
            n_fail++;
            $display("FAIL imm_wb op%0d: got state=%0d RegDst=%b MemtoReg=%b RegWrite=%b",
                     k, State, RegDst, MemtoReg, RegWrite);
          end
        end
        if (i == 4) begin
          n_checks++;
          if (State !== 4'd0) begin
            n_fail++; $display("FAIL imm_done op%0d: got %0d want 0", k, State);
          end
        end
        if (i < 4) tick();
      end
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0] exp_s [8];
    logic       mr [8];
    exp_s = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    mr    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    Op = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      MemReady = mr[i];
      #1;
      n_checks++;
      if (State !== exp_s[i]) begin
        n_fail++; $display("FAIL sw_state cyc%0d: got %0d want %0d", i, State, exp_s[i]);
      end
      n_checks++;
      if ({MemWrite, RegWrite} !== {(i >= 3 && i <= 6), 1'b0}) begin
        n_fail++;
        $display("FAIL sw_strobe cyc%0d: got MemWrite=%b RegWrite=%b want %b 0", i, MemWrite,
                 RegWrite, (i >= 3 && i <= 6));
      end
      if (i < 7) tick();
    end
  endtask

  task automatic test_fetch_timeout();
    Op = 6'b000000;
    MemReady = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      #1;
      n_checks++;
      if ({State, MemErr, IRWrite, PCWrite} !== {4'd0, (c == 16), 2'b00}) begin
        n_fail++;
        $display("FAIL fetch_to cyc%0d: got state=%0d MemErr=%b IRWrite=%b PCWrite=%b want 0 %b 0 0",
                 c, State, MemErr, IRWrite, PCWrite, (c == 16));
      end
      if (c < 17) tick();
    end
  endtask

  task automatic test_mem_timeouts();
    // lw stalled in MEMRD: abort on the 16th wait cycle, no writeback
    Op = 6'b100011;
    MemReady = 1'b1;
    #1;
    tick();
    MemReady = 1'b0;
    tick();
    tick();
    for (int c = 1; c <= 17; c++) begin
      #1;
      n_checks++;
      if ({State, MemErr, RegWrite} !== {((c == 17) ? 4'd0 : 4'd3), (c == 16), 1'b0}) begin
        n_fail++;
        $display("FAIL memrd_to cyc%0d: got state=%0d MemErr=%b RegWrite=%b", c, State, MemErr,
                 RegWrite);
      end
      if (c < 17) tick();
    end
    // sw with MemReady arriving on the last allowed cycle: normal completion
    Op = 6'b101011;
    MemReady = 1'b1;
    #1;
    tick();
    tick();
    tick();
    for (int c = 1; c <= 17; c++) begin
      MemReady = (c >= 16);
      #1;
      n_checks++;
      if ({State, MemErr} !== {((c == 17) ? 4'd0 : 4'd5), 1'b0}) begin
        n_fail++;
        $display("FAIL memwr_late cyc%0d: got state=%0d MemErr=%b", c, State, MemErr);
      end
      if (c < 17) tick();
    end
  endtask

  task automatic test_illegal();
    Op = 6'b111111;
    MemReady = 1'b1;
    #1;
    n_checks++;
    if (Illegal !== 1'b0) begin
      n_fail++; $display("FAIL illegal_fetch: got %b want 0", Illegal);
    end
    tick();
    n_checks++;
    if ({State, Illegal} !== {4'd1, 1'b1}) begin
      n_fail++; $display("FAIL illegal_decode: got state=%0d Illegal=%b want 1 1", State, Illegal);
    end
    tick();
    n_checks++;
    if ({State, Illegal} !== {4'd0, 1'b0}) begin
      n_fail++; $display("FAIL illegal_after: got state=%0d Illegal=%b want 0 0", State, Illegal);
    end
  endtask

  task automatic test_reset_midinstr();
    Op = 6'b100011;
    MemReady = 1'b1;
    #1;
    tick();
    tick();
    tick();
    MemReady = 1'b0;
    #1;
    n_checks++;
    if (State !== 4'd3) begin
      n_fail++; $display("FAIL rst_mid_pre: got %0d want 3", State);
    end
    rst_n = 1'b0;
    MemReady = 1'b1;
    #1;
    n_checks++;
    if ({State, IRWrite, PCWrite, RegWrite, MemWrite, MemRead, IorD} !== {4'd0, 6'd0}) begin
      n_fail++;
      $display("FAIL rst_mid: got state=%0d strobes=%b", State,
               {IRWrite, PCWrite, RegWrite, MemWrite, MemRead, IorD});
    end
    MemReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({State, MemRead} !== {4'd0, 1'b1}) begin
      n_fail++; $display("FAIL rst_mid_release: got state=%0d MemRead=%b want 0 1", State, MemRead);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_branch_jump();
    test_imm();
    test_sw_wait();
    test_fetch_timeout();
    test_mem_timeouts();
    test_illegal();
    test_reset_midinstr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
